duty_modulator_mlane: RTL and testbench
=======================================

Name: duty_modulator_mlane

Overview:
- Parametrised successor of the single-lane duty modulator.
- Scales a bank of DEPTH transducer duties by a global modulation value using LANES parallel pipelined multipliers.
- Adds selectable arithmetic modes, unity handling, an atomic output commit, a busy/pending handshake and synchronous reset.
- Sits between the duty/phase normaliser and the PWM generators, once per modulation sample.

Parameters:
- WIDTH, 13: duty width in bits.
- MOD_WIDTH, 8: modulation value width in bits.
- DEPTH, 249: number of duty channels.
- LANES, 1: parallel multipliers; 1..DEPTH; DEPTH need not be a multiple of LANES.
- MULT_LATENCY, 3: pipeline latency of each mult instance, in cycles.

Ports:
- CLK  in  1  system clock; all logic on posedge.
- RST_N  in  1  synchronous reset, active low.
- UPDATE  in  1  start request, level sampled each cycle.
- MOD  in  MOD_WIDTH  modulation value.
- MODE  in  2  arithmetic mode: 0 trunc, 1 round, 2 bypass, 3 mute.
- DUTY  in  WIDTH x DEPTH  unpacked array [0:DEPTH-1] of input duties.
- DUTY_M  out  WIDTH x DEPTH  unpacked array [0:DEPTH-1] of modulated duties.
- BUSY  out  1  calculation in progress.
- OUT_VALID  out  1  single-cycle pulse; DUTY_M was updated this cycle.

Behaviour:
- Reset (RST_N=0 at a posedge):
  - state IDLE; pending flag cleared.
  - BUSY=0, OUT_VALID=0, all DUTY_M=0, internal result buffer=0.
  - Reset mid-calculation aborts with no OUT_VALID; DUTY_M reads 0 from the next cycle.
- States:
  - IDLE: if UPDATE=1, snapshot all DUTY, MOD and MODE into shadow registers, then go to PROC.
  - PROC: issue LANES channels per cycle, for N = ceil(DEPTH/LANES) issue cycles. Lane j in issue cycle c handles channel c*LANES+j. Out-of-range lanes in the last cycle are issued but their results are discarded.
  - Then DRAIN for MULT_LATENCY+1 cycles, writing results into the internal buffer.
  - COMMIT: copy the whole buffer to DUTY_M in one cycle (atomic; DUTY_M never shows a partially updated set), assert OUT_VALID, return to IDLE.
- Latency: with UPDATE high in cycle k, OUT_VALID is high in exactly cycle k+L, where L = N + MULT_LATENCY + 2. DUTY_M holds new values from cycle k+L.
- BUSY is high in cycles k+1..k+L-1 and low in the OUT_VALID cycle.
- UPDATE while BUSY=1 sets pending and does not disturb the current shadow values.
  - In the COMMIT cycle, if pending is set, that cycle acts as an UPDATE cycle: fresh snapshot, pending cleared, BUSY stays high, next OUT_VALID at +L.
  - Multiple UPDATEs while busy collapse into one pending request.
- UPDATE in the OUT_VALID cycle with no pending request starts normally.
- Arithmetic, with P = duty*mod at full width WIDTH+MOD_WIDTH:
  - MODE0: out = P >> MOD_WIDTH.
  - MODE1: out = (P + 2^(MOD_WIDTH-1)) >> MOD_WIDTH, saturated to 2^WIDTH-1.
  - MODE0/1 with MOD = all-ones: out = duty exactly (unity override, applied in the pipeline at the same latency).
  - MODE2: out = duty.
  - MODE3: out = 0.
- All modes use the same latency L.
- MOD=0 in MODE0/1 gives out = 0.

Test Plan:
- WIDTH=13, MOD_WIDTH=8, DEPTH=249, LANES=1, MODE=0: all DUTY=4096, MOD=128, UPDATE pulse at cycle k -> BUSY high k+1..k+253; OUT_VALID only at k+254; all DUTY_M=2048. Repeat with LANES=4 -> OUT_VALID at k+68.
- DUTY[i]=3, MOD=128: MODE0 -> DUTY_M=1; MODE1 -> DUTY_M=2. DUTY[i]=8191, MOD=255: MODE0 and MODE1 -> 8191; MODE2 -> DUTY[i]; MODE3 -> 0.
- DEPTH=10, LANES=4, DUTY[i]=i*100, MOD=64 -> DUTY_M[i]=i*25 for all i; lanes 2..3 of the last issue cycle do not corrupt channel 0 or 1.
- UPDATE at k, then UPDATE at k+5 and k+9 with new DUTY=1000 and MOD=255 -> first OUT_VALID at k+L with the old values; BUSY stays high; second OUT_VALID at k+2L with DUTY_M=1000; no third pulse.
- DUTY input changed in cycle k+1 during PROC -> results reflect the cycle-k snapshot. DUTY_M stays at the previous values until the commit cycle, then all channels change in the same cycle.
- RST_N low for one cycle at k+50 -> no OUT_VALID; DUTY_M=0 and BUSY=0 from k+51; a new UPDATE at k+60 gives OUT_VALID at k+60+L.

Source files
------------

// File: rtl/duty_modulator_mlane.sv
// Scales a bank of DEPTH duties by one shared modulation value using LANES pipelined
// multipliers, then publishes the whole bank to DUTY_M in a single cycle.
module duty_modulator_mlane #(
   parameter int WIDTH        = 13,
   parameter int MOD_WIDTH    = 8,
   parameter int DEPTH        = 249,
   parameter int LANES        = 1,
   parameter int MULT_LATENCY = 3
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   input  logic                 UPDATE,
   input  logic [MOD_WIDTH-1:0] MOD,
   input  logic [1:0]           MODE,
   input  logic [WIDTH-1:0]     DUTY   [0:DEPTH-1],
   output logic [WIDTH-1:0]     DUTY_M [0:DEPTH-1],
   output logic                 BUSY,
   output logic                 OUT_VALID
);

   localparam int N    = (DEPTH + LANES - 1) / LANES;
   localparam int PW   = WIDTH + MOD_WIDTH;
   localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CMAX = (N > MULT_LATENCY + 1) ? N : MULT_LATENCY + 1;
   localparam int CW   = $clog2(CMAX + 1);
   localparam int LAST = MULT_LATENCY - 1;
   localparam logic [PW:0] RND = (PW + 1)'(1) << (MOD_WIDTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_PROC, S_DRAIN, S_COMMIT} state_t;

   state_t              r_state, w_state_nx;
   logic [CW-1:0]       r_cnt, w_cnt_nx;
   logic                r_pend, w_pend_nx;
   logic                w_snap, w_commit_ld;

   logic [WIDTH-1:0]     r_duty_sh [0:DEPTH-1];
   logic [MOD_WIDTH-1:0] r_mod_sh;
   logic [1:0]           r_mode_sh;
   logic [WIDTH-1:0]     r_buf [0:DEPTH-1];

   logic [LANES-1:0]     w_iss_vld;
   logic [IDXW-1:0]      w_iss_idx  [0:LANES-1];
   logic [WIDTH-1:0]     w_iss_duty [0:LANES-1];
   logic [PW-1:0]        w_iss_prod [0:LANES-1];

   logic [LANES-1:0]     r_vld_p   [0:MULT_LATENCY-1];
   logic [IDXW-1:0]      r_idx_p   [0:MULT_LATENCY-1][0:LANES-1];
   logic [WIDTH-1:0]     r_duty_p  [0:MULT_LATENCY-1][0:LANES-1];
   logic [PW-1:0]        r_prod_p  [0:MULT_LATENCY-1][0:LANES-1];
   logic [1:0]           r_mode_p  [0:MULT_LATENCY-1];
   logic                 r_unity_p [0:MULT_LATENCY-1];

   // Mode 1 can only exceed full scale through the rounding offset, so one carry bit suffices.
   function automatic logic [WIDTH-1:0] f_scale(input logic [PW-1:0]    prod,
                                                input logic [WIDTH-1:0] duty,
                                                input logic [1:0]       mode,
                                                input logic             unity);
      logic [WIDTH:0] q;
      q = (WIDTH + 1)'(({1'b0, prod} + RND) >> MOD_WIDTH);
      case (mode)
         2'd0:    f_scale = unity ? duty : prod[PW-1:MOD_WIDTH];
         2'd1:    f_scale = unity ? duty : (q[WIDTH] ? '1 : q[WIDTH-1:0]);
         2'd2:    f_scale = duty;
         default: f_scale = '0;
      endcase
   endfunction

   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      w_pend_nx  = r_pend;
      w_snap     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (UPDATE) begin
               w_snap     = 1'b1;
               w_state_nx = S_PROC;
               w_cnt_nx   = '0;
            end
         end
         S_PROC: begin
            if (UPDATE) w_pend_nx = 1'b1;
            if (r_cnt == CW'(N - 1)) begin
               w_state_nx = S_DRAIN;
               w_cnt_nx   = '0;
            end else begin
               w_cnt_nx = r_cnt + CW'(1);
            end
         end
         S_DRAIN: begin
            if (UPDATE) w_pend_nx = 1'b1;
            if (r_cnt == CW'(MULT_LATENCY)) begin
               w_state_nx = S_COMMIT;
               w_cnt_nx   = '0;
            end else begin
               w_cnt_nx = r_cnt + CW'(1);
            end
         end
         default: begin
            // A request queued during the run restarts straight from the commit cycle.
            w_pend_nx = 1'b0;
            if (r_pend || UPDATE) begin
               w_snap     = 1'b1;
               w_state_nx = S_PROC;
               w_cnt_nx   = '0;
            end else begin
               w_state_nx = S_IDLE;
            end
         end
      endcase
   end

   assign w_commit_ld = (r_state == S_DRAIN) && (r_cnt == CW'(MULT_LATENCY));
   assign OUT_VALID   = (r_state == S_COMMIT);
   assign BUSY        = (r_state == S_PROC) || (r_state == S_DRAIN) ||
                        ((r_state == S_COMMIT) && r_pend);

   // Lanes past the last channel stay invalid and read channel 0 harmlessly.
   always_comb begin
      for (int j = 0; j < LANES; j++) begin
         w_iss_vld[j]  = (r_state == S_PROC) && ((int'(r_cnt) * LANES + j) < DEPTH);
         w_iss_idx[j]  = w_iss_vld[j] ? IDXW'(int'(r_cnt) * LANES + j) : '0;
         w_iss_duty[j] = r_duty_sh[w_iss_idx[j]];
         w_iss_prod[j] = PW'(w_iss_duty[j]) * PW'(r_mod_sh);
      end
   end

   always_ff @(posedge CLK) begin
      if (w_snap) begin
         r_duty_sh <= DUTY;
         r_mod_sh  <= MOD;
         r_mode_sh <= MODE;
      end
      for (int j = 0; j < LANES; j++) begin
         r_idx_p[0][j]  <= w_iss_idx[j];
         r_duty_p[0][j] <= w_iss_duty[j];
         r_prod_p[0][j] <= w_iss_prod[j];
      end
      r_mode_p[0]  <= r_mode_sh;
      r_unity_p[0] <= (r_mod_sh == '1);
      for (int s = 1; s < MULT_LATENCY; s++) begin
         r_idx_p[s]   <= r_idx_p[s-1];
         r_duty_p[s]  <= r_duty_p[s-1];
         r_prod_p[s]  <= r_prod_p[s-1];
         r_mode_p[s]  <= r_mode_p[s-1];
         r_unity_p[s] <= r_unity_p[s-1];
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_pend  <= 1'b0;
         for (int s = 0; s < MULT_LATENCY; s++) r_vld_p[s] <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_buf[i]  <= '0;
            DUTY_M[i] <= '0;
         end
      end else begin
         r_state    <= w_state_nx;
         r_cnt      <= w_cnt_nx;
         r_pend     <= w_pend_nx;
         r_vld_p[0] <= w_iss_vld;
         for (int s = 1; s < MULT_LATENCY; s++) r_vld_p[s] <= r_vld_p[s-1];
         for (int j = 0; j < LANES; j++) begin
            if (r_vld_p[LAST][j])
               r_buf[r_idx_p[LAST][j]] <= f_scale(r_prod_p[LAST][j], r_duty_p[LAST][j],
                                                  r_mode_p[LAST], r_unity_p[LAST]);
         end
         if (w_commit_ld) DUTY_M <= r_buf;
      end
   end

endmodule

// File: tb/tb_duty_modulator_mlane.sv
// Directed scoreboard bench: a 249x1-lane instance and a 10x4-lane instance with a
// per-instance monitor that checks every OUT_VALID against queued expectations.
module tb_duty_modulator_mlane;

   localparam int W  = 13;
   localparam int MW = 8;
   localparam int DA = 249;
   localparam int DB = 10;
   localparam int LA = 249 + 3 + 2;
   localparam int LB = 3 + 3 + 2;

   typedef struct {
      int cyc;
      int base;
      int step;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          ua, ub;
   logic [MW-1:0] ma, mb;
   logic [1:0]    mda, mdb;
   logic [W-1:0]  da  [0:DA-1];
   logic [W-1:0]  dma [0:DA-1];
   logic [W-1:0]  db  [0:DB-1];
   logic [W-1:0]  dmb [0:DB-1];
   logic          busy_a, ov_a, busy_b, ov_b;

   exp_t qa[$];
   exp_t qb[$];
   exp_t ea, eb;
   int   cyc   = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   // {duty base, duty step, MOD, MODE, expected base, expected step}
   int   tv [0:6][0:5] = '{
      '{3,    0,  128, 0, 1,    0},
      '{3,    0,  128, 1, 2,    0},
      '{8191, 0,  255, 0, 8191, 0},
      '{8191, 0,  255, 1, 8191, 0},
      '{5000, 0,  0,   1, 0,    0},
      '{0,    32, 128, 0, 0,    16},
      '{0,    30, 77,  2, 0,    30}
   };

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   duty_modulator_mlane #(.WIDTH(W), .MOD_WIDTH(MW), .DEPTH(DA), .LANES(1), .MULT_LATENCY(3)) u_dut_a (
      .CLK(clk), .RST_N(rst_n), .UPDATE(ua), .MOD(ma), .MODE(mda), .DUTY(da),
      .DUTY_M(dma), .BUSY(busy_a), .OUT_VALID(ov_a));

   duty_modulator_mlane #(.WIDTH(W), .MOD_WIDTH(MW), .DEPTH(DB), .LANES(4), .MULT_LATENCY(3)) u_dut_b (
      .CLK(clk), .RST_N(rst_n), .UPDATE(ub), .MOD(mb), .MODE(mdb), .DUTY(db),
      .DUTY_M(dmb), .BUSY(busy_b), .OUT_VALID(ov_b));

   task automatic chk(input string nm, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   task automatic chk_bank_a(input exp_t e);
      int fi = -1;
      for (int i = 0; i < DA; i++)
         if (fi < 0 && dma[i] !== W'(e.base + e.step * i)) fi = i;
      n_cmp++;
      if (fi >= 0) begin
         n_bad++;
         $display("FAIL a_duty_m: ch %0d got %0d, required %0d (cycle %0d)",
                  fi, dma[fi], e.base + e.step * fi, cyc);
      end
   endtask

   task automatic chk_bank_b(input exp_t e);
      int fi = -1;
      for (int i = 0; i < DB; i++)
         if (fi < 0 && dmb[i] !== W'(e.base + e.step * i)) fi = i;
      n_cmp++;
      if (fi >= 0) begin
         n_bad++;
         $display("FAIL b_duty_m: ch %0d got %0d, required %0d (cycle %0d)",
                  fi, dmb[fi], e.base + e.step * fi, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (ov_a === 1'b1) begin
         if (qa.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL a_extra_valid: OUT_VALID at cycle %0d, none required", cyc);
         end else begin
            ea = qa.pop_front();
            chk("a_valid_cycle", cyc, ea.cyc);
            chk_bank_a(ea);
         end
      end
   end

   always @(negedge clk) begin
      if (ov_b === 1'b1) begin
         if (qb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL b_extra_valid: OUT_VALID at cycle %0d, none required", cyc);
         end else begin
            eb = qb.pop_front();
            chk("b_valid_cycle", cyc, eb.cyc);
            chk_bank_b(eb);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_cyc(input int t);
      while (cyc < t) tick(1);
   endtask

   task automatic go_a(input int dbase, input int dstep, input int m, input int md,
                       input int ebase, input int estep);
      exp_t e;
      for (int i = 0; i < DA; i++) da[i] = W'(dbase + dstep * i);
      ma  = MW'(m);
      mda = 2'(md);
      ua  = 1'b1;
      e.cyc = cyc + LA; e.base = ebase; e.step = estep;
      qa.push_back(e);
      tick(1);
      ua = 1'b0;
   endtask

   task automatic go_b(input int dbase, input int dstep, input int m, input int md,
                       input int ebase, input int estep);
      exp_t e;
      for (int i = 0; i < DB; i++) db[i] = W'(dbase + dstep * i);
      mb  = MW'(m);
      mdb = 2'(md);
      ub  = 1'b1;
      e.cyc = cyc + LB; e.base = ebase; e.step = estep;
      qb.push_back(e);
      tick(1);
      ub = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation stalled at cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int   k, k2;
      exp_t e;
      rst_n = 1'b0;
      ua = 1'b0; ub = 1'b0; ma = '0; mb = '0; mda = '0; mdb = '0;
      for (int i = 0; i < DA; i++) da[i] = '0;
      for (int i = 0; i < DB; i++) db[i] = '0;
      tick(3);
      rst_n = 1'b1;
      tick(1);
      chk("rst_busy_a", busy_a, 0);
      chk("rst_valid_a", ov_a, 0);
      chk("rst_dutym_a0", dma[0], 0);
      chk("rst_dutym_a248", dma[248], 0);
      chk("rst_busy_b", busy_b, 0);
      chk("rst_dutym_b9", dmb[9], 0);

      // Latency and BUSY window on the single-lane instance.
      k = cyc;
      chk("a_busy_before", busy_a, 0);
      go_a(4096, 0, 128, 0, 2048, 0);
      chk("a_busy_k1", busy_a, 1);
      wait_cyc(k + LA - 1);
      chk("a_busy_last", busy_a, 1);
      chk("a_valid_early", ov_a, 0);
      wait_cyc(k + LA);
      chk("a_busy_commit", busy_a, 0);
      chk("a_valid_commit", ov_a, 1);
      tick(1);

      for (int t = 0; t < 7; t++) begin
         k = cyc;
         go_a(tv[t][0], tv[t][1], tv[t][2], tv[t][3], tv[t][4], tv[t][5]);
         wait_cyc(k + LA + 1);
      end

      // Inputs disturbed right after the request; bank must hold until commit.
      k = cyc;
      go_a(4096, 0, 64, 0, 1024, 0);
      for (int i = 0; i < DA; i++) da[i] = '0;
      ma = '0;
      mda = 2'd3;
      wait_cyc(k + LA - 1);
      chk("a_hold_ch1", dma[1], 30);
      chk("a_hold_ch248", dma[248], 7440);
      wait_cyc(k + LA + 1);

      k = cyc;
      go_a(8191, 0, 255, 3, 0, 0);
      wait_cyc(k + LA + 1);

      // Two requests while busy collapse into one follow-on run.
      k = cyc;
      go_a(4096, 0, 128, 0, 2048, 0);
      wait_cyc(k + 5);
      for (int i = 0; i < DA; i++) da[i] = W'(1000);
      ma = 8'd255;
      ua = 1'b1;
      e.cyc = k + 2 * LA; e.base = 1000; e.step = 0;
      qa.push_back(e);
      tick(1);
      ua = 1'b0;
      wait_cyc(k + 9);
      ua = 1'b1;
      tick(1);
      ua = 1'b0;
      wait_cyc(k + LA);
      chk("a_busy_pending_commit", busy_a, 1);
      wait_cyc(k + 2 * LA);
      chk("a_busy_second_commit", busy_a, 0);
      wait_cyc(k + 3 * LA);
      chk("a_pending_queue", qa.size(), 0);

      // Abort by reset mid-run, then a clean restart.
      k = cyc;
      for (int i = 0; i < DA; i++) da[i] = W'(4096);
      ma = 8'd128; mda = 2'd0; ua = 1'b1;
      tick(1);
      ua = 1'b0;
      wait_cyc(k + 50);
      rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;
      chk("a_abort_busy", busy_a, 0);
      chk("a_abort_ch0", dma[0], 0);
      chk("a_abort_ch200", dma[200], 0);
      wait_cyc(k + 60);
      k2 = cyc;
      go_a(100, 0, 255, 1, 100, 0);
      wait_cyc(k2 + LA + 1);

      // Four-lane instance with a partly filled last issue cycle.
      k = cyc;
      go_b(0, 100, 64, 0, 0, 25);
      chk("b_busy_k1", busy_b, 1);
      wait_cyc(k + LB);
      chk("b_valid_commit", ov_b, 1);
      tick(1);
      k = cyc;
      go_b(100, 100, 64, 0, 25, 25);
      wait_cyc(k + LB + 1);
      k = cyc;
      go_b(7, 11, 9, 2, 7, 11);
      wait_cyc(k + LB + 1);
      k = cyc;
      go_b(3, 0, 128, 1, 2, 0);
      wait_cyc(k + LB + 1);

      tick(4);
      chk("a_queue_drained", qa.size(), 0);
      chk("b_queue_drained", qb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
